// File: rtl/ofm_wr_pkg.sv
// Shared types and constants for the OFM write sequencer.
package ofm_wr_pkg;

   localparam int CH_W   = 5;
   localparam int TILE_W = 14;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TILE = 3'd1,
      ST_ARM       = 3'd2,
      ST_DRAIN     = 3'd3,
      ST_GAP       = 3'd4,
      ST_DONE      = 3'd5
   } state_e;

   // Limits a requested channel count to the PE array dimension.
   function automatic logic [CH_W-1:0] clamp_ch(input logic [CH_W-1:0] req,
                                                input logic [CH_W-1:0] limit);
      return (req > limit) ? limit : req;
   endfunction

endpackage

// File: rtl/ofm_wr_perf_counter.sv
// Saturating 32-bit stall counter; only instantiated when OFM_WR_PERF_CNT_EN is defined.
module ofm_wr_perf_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        inc_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/ofm_write_sequencer.sv
// OFM write path sequencer: tile handoff, per-channel write beats, tile/layer counting.
// Optional stall performance counter enabled by defining OFM_WR_PERF_CNT_EN.
module ofm_write_sequencer
   import ofm_wr_pkg::*;
#(
   parameter int SYSTOLIC_SIZE = 16,
   parameter int TILE_W        = ofm_wr_pkg::TILE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [TILE_W-1:0] num_tiling,
   input  logic [4:0]        read_wgt_size,
   input  logic              tile_valid,
   output logic              tile_ack,
   input  logic              ofm_ready,
   output logic              addr_write,
   output logic              ofm_we,
   output logic [4:0]        buf_rd_ch,
   output logic              busy,
   output logic              layer_done,
   output logic              cfg_err,
   output logic [31:0]       stall_cycles
);

   localparam logic [CH_W-1:0]   MAX_CH   = CH_W'(SYSTOLIC_SIZE);
   localparam logic [CH_W-1:0]   CH_ONE   = CH_W'(1);
   localparam logic [TILE_W-1:0] TILE_ONE = TILE_W'(1);

   state_e            state_q, state_d;
   logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
   logic [TILE_W-1:0] ntile_q, ntile_d;
   logic [CH_W-1:0]   rws_q, rws_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              cfg_err_q, cfg_err_d;
   logic              start_accept;

   // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      tile_cnt_d   = tile_cnt_q;
      ntile_d      = ntile_q;
      rws_d        = rws_q;
      ch_d         = ch_q;
      cfg_err_d    = 1'b0;
      start_accept = 1'b0;

      if (abort) begin
         state_d = ST_IDLE;
         ch_d    = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if ((num_tiling == '0) || (read_wgt_size == '0)) begin
                     cfg_err_d = 1'b1;
                  end else begin
                     start_accept = 1'b1;
                     ntile_d      = num_tiling;
                     rws_d        = clamp_ch(read_wgt_size, MAX_CH);
                     tile_cnt_d   = '0;
                     state_d      = ST_WAIT_TILE;
                  end
               end
            end
            ST_WAIT_TILE: begin
               if (tile_valid && ofm_ready) state_d = ST_ARM;
            end
            ST_ARM: begin
               ch_d    = '0;
               state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (ch_q == rws_q - CH_ONE) begin
                  ch_d    = '0;
                  state_d = ST_GAP;
               end else begin
                  ch_d = ch_q + CH_ONE;
               end
            end
            ST_GAP: begin
               // Full-width compare against the latched count; the tile counter never wraps.
               if (tile_cnt_q == ntile_q - TILE_ONE) begin
                  state_d = ST_DONE;
               end else begin
                  tile_cnt_d = tile_cnt_q + TILE_ONE;
                  state_d    = ST_WAIT_TILE;
               end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tile_cnt_q <= '0;
         ntile_q    <= '0;
         rws_q      <= '0;
         ch_q       <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tile_cnt_q <= tile_cnt_d;
         ntile_q    <= ntile_d;
         rws_q      <= rws_d;
         ch_q       <= ch_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign addr_write = (state_q == ST_ARM);
   assign ofm_we     = (state_q == ST_DRAIN);
   assign buf_rd_ch  = (state_q == ST_DRAIN) ? ch_q : '0;
   assign tile_ack   = (state_q == ST_GAP);
   assign layer_done = (state_q == ST_DONE);
   assign busy       = (state_q != ST_IDLE);
   assign cfg_err    = cfg_err_q;

`ifdef OFM_WR_PERF_CNT_EN
   logic stall_inc;

   assign stall_inc = (state_q == ST_WAIT_TILE) && tile_valid && !ofm_ready;

   ofm_wr_perf_counter u_perf_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (start_accept),
      .inc_i  (stall_inc),
      .count_o(stall_cycles)
   );
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ofm_write_sequencer.sv
// Directed bench for ofm_write_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_ofm_write_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [13:0] num_tiling;
   logic [4:0]  read_wgt_size;
   logic        tile_valid;
   logic        tile_ack;
   logic        ofm_ready;
   logic        addr_write;
   logic        ofm_we;
   logic [4:0]  buf_rd_ch;
   logic        busy;
   logic        layer_done;
   logic        cfg_err;
   logic [31:0] stall_cycles;

   int total = 0;
   int bad   = 0;

`ifdef OFM_WR_PERF_CNT_EN
   localparam logic [31:0] EXP_STALL = 32'd10;
`else
   localparam logic [31:0] EXP_STALL = 32'd0;
`endif

   always #5 clk = ~clk;

   ofm_write_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .num_tiling   (num_tiling),
      .read_wgt_size(read_wgt_size),
      .tile_valid   (tile_valid),
      .tile_ack     (tile_ack),
      .ofm_ready    (ofm_ready),
      .addr_write   (addr_write),
      .ofm_we       (ofm_we),
      .buf_rd_ch    (buf_rd_ch),
      .busy         (busy),
      .layer_done   (layer_done),
      .cfg_err      (cfg_err),
      .stall_cycles (stall_cycles)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " busy"},       {31'd0, busy},       32'd0);
      check({tag, " addr_write"}, {31'd0, addr_write}, 32'd0);
      check({tag, " ofm_we"},     {31'd0, ofm_we},     32'd0);
      check({tag, " buf_rd_ch"},  {27'd0, buf_rd_ch},  32'd0);
      check({tag, " tile_ack"},   {31'd0, tile_ack},   32'd0);
      check({tag, " layer_done"}, {31'd0, layer_done}, 32'd0);
      check({tag, " cfg_err"},    {31'd0, cfg_err},    32'd0);
   endtask

   // Starting at the ARM cycle: one addr_write, nbeats beats, ending on the GAP cycle.
   task automatic run_tile(input string tag, input int nbeats);
      check({tag, " arm addr_write"}, {31'd0, addr_write}, 32'd1);
      check({tag, " arm ofm_we"},     {31'd0, ofm_we},     32'd0);
      for (int i = 0; i < nbeats; i++) begin
         tick();
         check({tag, " beat ofm_we"},     {31'd0, ofm_we},     32'd1);
         check({tag, " beat buf_rd_ch"},  {27'd0, buf_rd_ch},  32'(i));
         check({tag, " beat addr_write"}, {31'd0, addr_write}, 32'd0);
      end
      tick();
      check({tag, " gap tile_ack"}, {31'd0, tile_ack}, 32'd1);
      check({tag, " gap ofm_we"},   {31'd0, ofm_we},   32'd0);
   endtask

   initial begin
      int beats;
      logic [4:0] last_ch;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_tiling = '0;
      read_wgt_size = '0; tile_valid = 1'b0; ofm_ready = 1'b0;

      // Reset state
      tick(); tick();
      check_quiet("reset");
      check("reset stall", stall_cycles, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1. Basic two-tile layer, 4 channels
      start = 1'b1; num_tiling = 14'd2; read_wgt_size = 5'd4; tile_valid = 1'b1; ofm_ready = 1'b1;
      tick();
      start = 1'b0;
      check("t1 busy", {31'd0, busy}, 32'd1);
      check("t1 wait addr_write", {31'd0, addr_write}, 32'd0);
      tick();
      run_tile("t1 tile0", 4);
      check("t1 gap0 layer_done", {31'd0, layer_done}, 32'd0);
      tick();
      check("t1 wait2 tile_ack", {31'd0, tile_ack}, 32'd0);
      check("t1 wait2 busy", {31'd0, busy}, 32'd1);
      check("t1 wait2 layer_done", {31'd0, layer_done}, 32'd0);
      tick();
      run_tile("t1 tile1", 4);
      check("t1 gap1 layer_done", {31'd0, layer_done}, 32'd0);
      tick();
      check("t1 done layer_done", {31'd0, layer_done}, 32'd1);
      check("t1 done tile_ack", {31'd0, tile_ack}, 32'd0);
      tick();
      check_quiet("t1 idle");

      // 2. Backpressure: ofm_ready low for 10 cycles
      ofm_ready = 1'b0; start = 1'b1; num_tiling = 14'd1; read_wgt_size = 5'd2;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("t2 hold addr_write", {31'd0, addr_write}, 32'd0);
         check("t2 hold busy", {31'd0, busy}, 32'd1);
         tick();
      end
      ofm_ready = 1'b1;
      tick();
      run_tile("t2 tile", 2);
      tick();
      check("t2 layer_done", {31'd0, layer_done}, 32'd1);
      tick();
      check("t2 stall_cycles", stall_cycles, EXP_STALL);

      // 3. Zero config
      start = 1'b1; num_tiling = 14'd3; read_wgt_size = 5'd0;
      tick();
      start = 1'b0;
      check("t3 rws0 cfg_err", {31'd0, cfg_err}, 32'd1);
      check("t3 rws0 busy", {31'd0, busy}, 32'd0);
      tick();
      check_quiet("t3 rws0 after");
      start = 1'b1; num_tiling = 14'd0; read_wgt_size = 5'd4;
      tick();
      start = 1'b0;
      check("t3 nt0 cfg_err", {31'd0, cfg_err}, 32'd1);
      check("t3 nt0 busy", {31'd0, busy}, 32'd0);
      tick();
      check_quiet("t3 nt0 after");
      check("t3 stall kept", stall_cycles, EXP_STALL);

      // 4. Abort in DRAIN after 2 of 16 beats
      start = 1'b1; num_tiling = 14'd1; read_wgt_size = 5'd16;
      tick();
      start = 1'b0;
      tick();
      check("t4 arm", {31'd0, addr_write}, 32'd1);
      tick();
      check("t4 beat0 ch", {27'd0, buf_rd_ch}, 32'd0);
      tick();
      check("t4 beat1 ch", {27'd0, buf_rd_ch}, 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_quiet("t4 aborted");
      tick();
      check_quiet("t4 aborted+1");

      // 5. Full width single tile; a start mid-tile must be ignored
      start = 1'b1; num_tiling = 14'd1; read_wgt_size = 5'd16;
      tick();
      start = 1'b0;
      tick();
      check("t5 arm", {31'd0, addr_write}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         tick();
         check("t5 beat ofm_we", {31'd0, ofm_we}, 32'd1);
         check("t5 beat ch", {27'd0, buf_rd_ch}, 32'(i));
         if (i == 3) begin
            start = 1'b1; num_tiling = 14'd5; read_wgt_size = 5'd2;
         end else begin
            start = 1'b0;
         end
      end
      tick();
      check("t5 gap tile_ack", {31'd0, tile_ack}, 32'd1);
      check("t5 gap layer_done", {31'd0, layer_done}, 32'd0);
      tick();
      check("t5 done tile_ack", {31'd0, tile_ack}, 32'd0);
      check("t5 done layer_done", {31'd0, layer_done}, 32'd1);
      tick();
      check_quiet("t5 idle");

      // 5b. Oversized channel request clamps to 16 beats
      start = 1'b1; num_tiling = 14'd1; read_wgt_size = 5'd31;
      tick();
      start = 1'b0;
      beats = 0; last_ch = '0;
      for (int i = 0; i < 40 && !layer_done; i++) begin
         if (ofm_we) begin
            beats++;
            last_ch = buf_rd_ch;
         end
         tick();
      end
      check("t5b layer_done seen", {31'd0, layer_done}, 32'd1);
      check("t5b beats", 32'(beats), 32'd16);
      check("t5b last ch", {27'd0, last_ch}, 32'd15);
      tick();

      // 6. Async reset in DRAIN
      start = 1'b1; num_tiling = 14'd2; read_wgt_size = 5'd8;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      check("t6 in drain", {31'd0, ofm_we}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_quiet("t6 async reset");
      start = 1'b1; num_tiling = 14'd1; read_wgt_size = 5'd1;
      tick(); tick();
      check("t6 start in reset busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1; start = 1'b0;
      tick();
      check_quiet("t6 after release");

      // Normal run after reset: 1 tile, 1 channel
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      run_tile("t6 rerun", 1);
      tick();
      check("t6 rerun layer_done", {31'd0, layer_done}, 32'd1);
      tick();
      check_quiet("t6 rerun idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
